multicycle_main_fsm: RTL and testbench

- Main sequencing FSM for the multicycle ARM core control unit.
- Each cycle it produces the datapath mux selects (address, ALU operands, result) and the raw write strobes RegW, MemW and Branch. The conditional-logic stage gates these strobes with the condition check before they reach the register file, memory and PC.
- Adds a memory-ready handshake so instruction and data accesses can stretch over wait states.
- Keeps a retired-instruction counter for performance measurement during image-equalization runs.

---
 rtl/multicycle_main_fsm_if.sv | 34 +++
 rtl/multicycle_main_fsm.sv | 134 +++++++++++++
 tb/tb_multicycle_main_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_fsm_if.sv
// Control-unit bundle between the main sequencing FSM and the multicycle datapath.
// master = FSM side (samples instruction fields and mem_ready, drives selects/strobes).
interface multicycle_main_fsm_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             mem_ready;
    logic             IRWrite;
    logic             NextPC;
    logic             AdrSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             ALUOp;
    logic             RegW;
    logic             MemW;
    logic             Branch;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  Op, Funct, mem_ready,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               RegW, MemW, Branch, illegal_op, state, retired
    );

    modport slave (
        output Op, Funct, mem_ready,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               RegW, MemW, Branch, illegal_op, state, retired
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Multicycle ARM main control FSM: Moore selects/strobes registered per state, IRWrite/NextPC gated by mem_ready.
// Latency ALU 4 / B 3 / LDR 5 / STR 4 cycles; mem_ready low in FETCH, MEMRD or MEMWR holds the state one more cycle.
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_main_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH, S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_MEMADR: c.alu_src_b = 2'b01;
            S_MEMRD:  c.adr_src   = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_EXECR: c.alu_op = 1'b1;
            S_EXECI: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            S_ALUWB: c.reg_w = 1'b1;
            S_BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_retired;
    state_t           w_next;
    logic             w_retire;
    logic             w_unused_funct;

    assign w_unused_funct = ^bus.Funct[4:1];

    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                w_next   = bus.mem_ready ? S_FETCH : S_MEMWR;
                w_retire = bus.mem_ready;
            end
            S_EXECR, S_EXECI: w_next = S_ALUWB;
            S_ALUWB, S_MEMWB, S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Output register is loaded with the decode of the state being entered, so it always matches r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ctrl    <= f_decode(S_FETCH);
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next);
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign bus.IRWrite    = (r_state == S_FETCH) & bus.mem_ready;
    assign bus.NextPC     = (r_state == S_FETCH) & bus.mem_ready;
    assign bus.illegal_op = (r_state == S_DECODE) & (bus.Op == 2'b11);
    assign bus.AdrSrc     = r_ctrl.adr_src;
    assign bus.ALUSrcA    = r_ctrl.alu_src_a;
    assign bus.ALUSrcB    = r_ctrl.alu_src_b;
    assign bus.ResultSrc  = r_ctrl.result_src;
    assign bus.ALUOp      = r_ctrl.alu_op;
    assign bus.RegW       = r_ctrl.reg_w;
    assign bus.MemW       = r_ctrl.mem_w;
    assign bus.Branch     = r_ctrl.branch;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares; a CNT_W=4 twin checks counter wrap.
module tb_multicycle_main_fsm;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_main_fsm_if #(.CNT_W(32)) bus  ();
    multicycle_main_fsm_if #(.CNT_W(4))  bus4 ();

    multicycle_main_fsm #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
    multicycle_main_fsm #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [12:0] ctrl;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   idx_cnt = 0;

    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,illegal_op}
    function automatic logic [12:0] exp_ctrl(input logic [3:0] st, input logic rdy, input logic [1:0] op);
        case (st)
            4'd0:    return {rdy, rdy, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 4'b0000};
            4'd1:    return {3'b000, 1'b1, 2'b10, 2'b10, 1'b0, 3'b000, (op == 2'b11)};
            4'd2:    return {4'b0000, 2'b01, 2'b00, 1'b0, 4'b0000};
            4'd3:    return {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0000};
            4'd4:    return {4'b0000, 2'b00, 2'b01, 1'b0, 4'b1000};
            4'd5:    return {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0100};
            4'd6:    return {4'b0000, 2'b00, 2'b00, 1'b1, 4'b0000};
            4'd7:    return {4'b0000, 2'b01, 2'b00, 1'b1, 4'b0000};
            4'd8:    return {4'b0000, 2'b00, 2'b00, 1'b0, 4'b1000};
            4'd9:    return {4'b0000, 2'b01, 2'b10, 1'b0, 4'b0010};
            default: return 13'h0;
        endcase
    endfunction

    function automatic void check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
        end
    endfunction

    task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic rdy,
                         input logic [3:0] st, input logic [31:0] ret);
        exp_t e;
        bus.Op  = op;  bus.Funct  = f; bus.mem_ready  = rdy;
        bus4.Op = op;  bus4.Funct = f; bus4.mem_ready = rdy;
        e.idx  = idx_cnt;
        e.st   = st;
        e.ctrl = exp_ctrl(st, rdy, op);
        e.ret  = ret;
        idx_cnt++;
        sb.push_back(e);
    endtask

    task automatic step(input logic [1:0] op, input logic [5:0] f, input logic rdy,
                        input logic [3:0] st, input logic [31:0] ret);
        @(posedge clk);
        #1;
        apply(op, f, rdy, st, ret);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", e.idx, {28'h0, bus.state}, {28'h0, e.st});
            check("ctrl", e.idx,
                  {19'h0, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                   bus.ALUOp, bus.RegW, bus.MemW, bus.Branch, bus.illegal_op},
                  {19'h0, e.ctrl});
            check("retired", e.idx, bus.retired, e.ret);
            check("retired4", e.idx, {28'h0, bus4.retired}, e.ret & 32'hF);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.Op  = 2'b00; bus.Funct  = 6'h00; bus.mem_ready  = 1'b1;
        bus4.Op = 2'b00; bus4.Funct = 6'h00; bus4.mem_ready = 1'b1;
        #2;
        check("rst_state", -1, {28'h0, bus.state}, 32'd0);
        check("rst_retired", -1, bus.retired, 32'd0);
        check("rst_irwrite", -1, {31'h0, bus.IRWrite}, 32'd1);
        check("rst_alusrcb", -1, {30'h0, bus.ALUSrcB}, 32'd2);

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // ADD register
        apply(2'b00, 6'h00, 1'b1, 4'd0, 0);
        step(2'b00, 6'h00, 1'b1, 4'd1, 0);
        step(2'b00, 6'h00, 1'b1, 4'd6, 0);
        step(2'b00, 6'h00, 1'b1, 4'd8, 0);
        // LDR with two MEMRD wait states
        step(2'b01, 6'h01, 1'b1, 4'd0, 1);
        step(2'b01, 6'h01, 1'b1, 4'd1, 1);
        step(2'b01, 6'h01, 1'b1, 4'd2, 1);
        step(2'b01, 6'h01, 1'b0, 4'd3, 1);
        step(2'b01, 6'h01, 1'b0, 4'd3, 1);
        step(2'b01, 6'h01, 1'b1, 4'd3, 1);
        step(2'b01, 6'h01, 1'b1, 4'd4, 1);
        // STR with one MEMWR wait state
        step(2'b01, 6'h00, 1'b1, 4'd0, 2);
        step(2'b01, 6'h00, 1'b1, 4'd1, 2);
        step(2'b01, 6'h00, 1'b1, 4'd2, 2);
        step(2'b01, 6'h00, 1'b0, 4'd5, 2);
        step(2'b01, 6'h00, 1'b1, 4'd5, 2);
        // Branch, then illegal Op=11
        step(2'b10, 6'h00, 1'b1, 4'd0, 3);
        step(2'b10, 6'h00, 1'b1, 4'd1, 3);
        step(2'b10, 6'h00, 1'b1, 4'd9, 3);
        step(2'b11, 6'h00, 1'b1, 4'd0, 4);
        step(2'b11, 6'h00, 1'b1, 4'd1, 4);
        // ADD immediate with a FETCH wait state; mem_ready low in DECODE is ignored
        step(2'b00, 6'h20, 1'b0, 4'd0, 4);
        step(2'b00, 6'h20, 1'b1, 4'd0, 4);
        step(2'b00, 6'h20, 1'b0, 4'd1, 4);
        step(2'b00, 6'h20, 1'b1, 4'd7, 4);
        step(2'b00, 6'h20, 1'b1, 4'd8, 4);
        // 16 back-to-back branches: 4-bit counter passes 15 -> 0
        for (int k = 0; k < 16; k++) begin
            step(2'b10, 6'h00, 1'b1, 4'd0, 32'(5 + k));
            step(2'b10, 6'h00, 1'b1, 4'd1, 32'(5 + k));
            step(2'b10, 6'h00, 1'b1, 4'd9, 32'(5 + k));
        end
        // STR stalled in MEMWR, then reset mid-cycle
        step(2'b01, 6'h00, 1'b1, 4'd0, 21);
        step(2'b01, 6'h00, 1'b1, 4'd1, 21);
        step(2'b01, 6'h00, 1'b1, 4'd2, 21);
        step(2'b01, 6'h00, 1'b0, 4'd5, 21);
        #6;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus4.mem_ready = 1'b1;
        #1;
        check("midrst_state", -1, {28'h0, bus.state}, 32'd0);
        check("midrst_memw", -1, {31'h0, bus.MemW}, 32'd0);
        check("midrst_retired", -1, bus.retired, 32'd0);
        check("midrst_retired4", -1, {28'h0, bus4.retired}, 32'd0);
        check("midrst_irwrite", -1, {31'h0, bus.IRWrite}, 32'd1);
        check("midrst_alusrc", -1, {29'h0, bus.ALUSrcA, bus.ALUSrcB}, 32'd6);
        @(posedge clk);
        #1;
        check("inrst_state", -1, {28'h0, bus.state}, 32'd0);
        check("inrst_strobes", -1, {28'h0, bus.RegW, bus.MemW, bus.Branch, bus.illegal_op}, 32'd0);
        reset = 1'b0;
        // Fresh branch after reset: the interrupted store is not resumed nor counted
        apply(2'b10, 6'h00, 1'b1, 4'd0, 0);
        step(2'b10, 6'h00, 1'b1, 4'd1, 0);
        step(2'b10, 6'h00, 1'b1, 4'd9, 0);
        step(2'b10, 6'h00, 1'b1, 4'd0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", -1, sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
